// File: rtl/div_request_sequencer.sv
// div_request_sequencer: front-end for the iterative integer divider.
// Samples operands on a start rising edge, issues a one-cycle div_go, waits
// for div_done (bounded by TIMEOUT cycles), captures the divider result and
// holds it with a res_valid/res_ack handshake.
// Ports:
//   CLK, RST        clock (rising edge), async active-low reset
//   start           rising edge requests a division
//   op_dividend/op_divisor   operands, sampled on an accepted start edge
//   res_ack         consumer took the result (honoured in HOLD only)
//   div_go          one-cycle pulse to the divider
//   div_dividend/div_divisor latched operands presented to the divider
//   div_done/div_err/div_quotient/div_remainder  divider response
//   busy            high in LOAD, GO, WAIT
//   res_valid/res_quotient/res_remainder/res_err/res_timeout  held result
//   state           current state code (debug)
module div_request_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 31,
  parameter int unsigned TCNT_W  = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] op_dividend,
  input  logic [WIDTH-1:0] op_divisor,
  input  logic             res_ack,
  output logic             div_go,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic             div_err,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_quotient,
  output logic [WIDTH-1:0] res_remainder,
  output logic             res_err,
  output logic             res_timeout,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_LOAD = 3'b001,
    S_GO   = 3'b010,
    S_WAIT = 3'b011,
    S_HOLD = 3'b100
  } state_e;

  state_e              state_q, state_d;
  logic                start_q;
  logic                start_edge_c;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [WIDTH-1:0]    dividend_d, divisor_d;
  logic [WIDTH-1:0]    quot_d, rem_d;
  logic                err_d, tmo_d, valid_d, go_d, busy_d;

  assign start_edge_c = start & ~start_q;
  assign state        = state_q;

  // Next-state and next-output logic; every register's next value defaults to hold.
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    dividend_d = div_dividend;
    divisor_d  = div_divisor;
    quot_d     = res_quotient;
    rem_d      = res_remainder;
    err_d      = res_err;
    tmo_d      = res_timeout;
    valid_d    = res_valid;

    case (state_q)
      S_IDLE: begin
        if (start_edge_c) begin
          dividend_d = op_dividend;
          divisor_d  = op_divisor;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: state_d = S_GO;
      S_GO: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        // Done takes priority over a coincident timeout.
        if (div_done) begin
          quot_d  = div_quotient;
          rem_d   = div_remainder;
          err_d   = div_err;
          tmo_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else if (tcnt_q == TCNT_W'(TIMEOUT)) begin
          quot_d  = '0;
          rem_d   = '0;
          err_d   = 1'b0;
          tmo_d   = 1'b1;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // A new request replaces the held result even without an ack.
        if (start_edge_c) begin
          valid_d    = 1'b0;
          dividend_d = op_dividend;
          divisor_d  = op_divisor;
          state_d    = S_LOAD;
        end else if (res_ack) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    go_d   = (state_d == S_GO);
    busy_d = (state_d == S_LOAD) || (state_d == S_GO) || (state_d == S_WAIT);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      tcnt_q        <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      res_quotient  <= '0;
      res_remainder <= '0;
      res_err       <= 1'b0;
      res_timeout   <= 1'b0;
      res_valid     <= 1'b0;
      div_go        <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start;
      tcnt_q        <= tcnt_d;
      div_dividend  <= dividend_d;
      div_divisor   <= divisor_d;
      res_quotient  <= quot_d;
      res_remainder <= rem_d;
      res_err       <= err_d;
      res_timeout   <= tmo_d;
      res_valid     <= valid_d;
      div_go        <= go_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_div_request_sequencer.sv
// tb_div_request_sequencer: directed bench for div_request_sequencer with a
// behavioural divider stub of programmable latency (done can be suppressed).
module tb_div_request_sequencer;

  localparam int unsigned WIDTH = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             start;
  logic [WIDTH-1:0] op_dividend, op_divisor;
  logic             res_ack;
  logic             div_go;
  logic [WIDTH-1:0] div_dividend, div_divisor;
  logic             div_done, div_err;
  logic [WIDTH-1:0] div_quotient, div_remainder;
  logic             busy, res_valid, res_err, res_timeout;
  logic [WIDTH-1:0] res_quotient, res_remainder;
  logic [2:0]       state;

  int errors = 0;
  int checks = 0;
  int lat    = 2;
  bit stub_en = 1'b1;
  int cnt;

  always #5 CLK = ~CLK;

  div_request_sequencer #(.WIDTH(4), .TIMEOUT(31), .TCNT_W(5)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .op_dividend(op_dividend), .op_divisor(op_divisor), .res_ack(res_ack),
    .div_go(div_go), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_err(div_err),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .busy(busy), .res_valid(res_valid), .res_quotient(res_quotient),
    .res_remainder(res_remainder), .res_err(res_err),
    .res_timeout(res_timeout), .state(state)
  );

  // Divider stub: done (level) rises lat cycles after go is sampled.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= 0; div_done <= 1'b0; div_err <= 1'b0;
      div_quotient <= '0; div_remainder <= '0;
    end else if (div_go) begin
      cnt <= lat; div_done <= 1'b0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1 && stub_en) begin
        div_done <= 1'b1;
        if (div_divisor == '0) begin
          div_err <= 1'b1; div_quotient <= '1; div_remainder <= div_dividend;
        end else begin
          div_err <= 1'b0;
          div_quotient  <= div_dividend / div_divisor;
          div_remainder <= div_dividend % div_divisor;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with start low; returns at the negedge where state=LOAD.
  task automatic do_start(input logic [3:0] a, input logic [3:0] b);
    @(negedge CLK);
    op_dividend = a; op_divisor = b; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Runs until res_valid (bounded); optionally pulses start at cycle inject_at.
  task automatic run_op(input int inject_at, output int cyc, output int gos);
    cyc = 0; gos = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge CLK);
      start = (k == inject_at);
      if (div_go) gos++;
      if (res_valid) begin cyc = k; break; end
    end
    start = 1'b0;
    check("run_bound_valid", res_valid, 1);
  endtask

  task automatic do_ack;
    res_ack = 1'b1;
    @(negedge CLK);
    res_ack = 1'b0;
  endtask

  int cyc, gos, first;

  initial begin
    RST = 1'b0; start = 1'b0; res_ack = 1'b0;
    op_dividend = '0; op_divisor = '0;
    #12;
    // Reset state
    check("rst_state", state, 0);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_go", div_go, 0);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);

    // 1: 13/3, latency 3 + 2
    lat = 2;
    do_start(4'd13, 4'd3);
    check("t1_load_state", state, 1);
    check("t1_dividend", div_dividend, 13);
    check("t1_busy", busy, 1);
    run_op(0, cyc, gos);
    check("t1_latency", cyc, 5);
    check("t1_go_count", gos, 1);
    check("t1_q", res_quotient, 4);
    check("t1_r", res_remainder, 1);
    check("t1_err", res_err, 0);
    check("t1_state_hold", state, 4);
    check("t1_busy_hold", busy, 0);
    do_ack;
    check("t1_ack_valid", res_valid, 0);
    check("t1_ack_state", state, 0);
    check("t1_keep_q", res_quotient, 4);

    // 2: 9/0 -> err
    do_start(4'd9, 4'd0);
    run_op(0, cyc, gos);
    check("t2_err", res_err, 1);
    check("t2_tmo", res_timeout, 0);
    do_ack;
    check("t2_ack_state", state, 0);

    // 4a: start held high 20 cycles, 8/2 with latency 4
    lat = 4; gos = 0; first = 0;
    @(negedge CLK);
    op_dividend = 4'd8; op_divisor = 4'd2; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (div_go) gos++;
      if (res_valid && first == 0) first = k;
    end
    start = 1'b0;
    check("t4_go_count", gos, 1);
    check("t4_first_valid", first, 8);
    check("t4_q", res_quotient, 4);
    @(negedge CLK);
    check("t4_still_hold", state, 4);
    do_ack;
    // 4b: edge inside WAIT ignored, 14/5 latency 10
    lat = 10;
    do_start(4'd14, 4'd5);
    run_op(3, cyc, gos);
    check("t4b_go_count", gos, 1);
    check("t4b_latency", cyc, 13);
    check("t4b_q", res_quotient, 2);
    check("t4b_r", res_remainder, 4);
    @(negedge CLK);
    check("t4b_no_requeue", state, 4);
    do_ack;

    // 5: 15/4 then 7/2 without ack
    lat = 2;
    do_start(4'd15, 4'd4);
    run_op(0, cyc, gos);
    check("t5_q1", res_quotient, 3);
    check("t5_r1", res_remainder, 3);
    do_start(4'd7, 4'd2);
    check("t5_valid_clr", res_valid, 0);
    check("t5_reload", state, 1);
    check("t5_dividend2", div_dividend, 7);
    run_op(0, cyc, gos);
    check("t5_q2", res_quotient, 3);
    check("t5_r2", res_remainder, 1);
    do_ack;

    // 6: async reset during WAIT
    lat = 6;
    do_start(4'd10, 4'd3);
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    check("t6_in_wait", state, 3);
    #2 RST = 1'b0;
    #1;
    check("t6_rst_state", state, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_q", res_quotient, 0);
    check("t6_rst_dividend", div_dividend, 0);
    check("t6_rst_valid", res_valid, 0);
    @(negedge CLK); RST = 1'b1;
    lat = 2;
    do_start(4'd6, 4'd6);
    run_op(0, cyc, gos);
    check("t6_q", res_quotient, 1);
    check("t6_r", res_remainder, 0);
    do_ack;

    // 3: divider never answers -> timeout after 1 GO cycle + 32 WAIT cycles
    stub_en = 1'b0;
    do_start(4'd5, 4'd1);
    run_op(0, cyc, gos);
    check("t3_latency", cyc, 34);
    check("t3_tmo", res_timeout, 1);
    check("t3_q_zero", res_quotient, 0);
    check("t3_r_zero", res_remainder, 0);
    check("t3_err", res_err, 0);
    do_ack;
    check("t3_ack_state", state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
